// File: rtl/core_mem_responder_if.sv
// Data-port bundle between the RISC-V core (master) and core_mem_responder (slave).
interface core_mem_responder_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_busy;
    logic        dmem_err;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready, dmem_busy, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready, dmem_busy, dmem_err
    );
endinterface

// File: rtl/core_mem_responder.sv
// Shared instruction/data word memory: registered fetch port plus a wait-state data FSM.
// Optional alignment checking on the data port is enabled by defining DMEM_ALIGN_CHECK_EN.
module core_mem_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          imem_addr,
    output logic [31:0]          imem_rdata,
    core_mem_responder_if.slave  dmem
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_BUSY = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic [31:0]   mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q;
    logic [31:0]   imem_rdata_q;
    logic          commit;
    logic          blocked;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] fetch_idx;
    logic          unused_addr_bits;

    // Upper bits alias; the byte offset only matters to the optional alignment check.
    assign unused_addr_bits = ^{imem_addr[31:AW+2], imem_addr[1:0],
                                dmem.dmem_addr[31:AW+2], dmem.dmem_addr[1:0]};
    assign fetch_idx = imem_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic blocked_q, blocked_d;
    logic misaligned;

    assign misaligned = ((dmem.dmem_addr[1:0] != 2'b00) && (dmem.dmem_wstrb == 4'hF)) ||
                        (dmem.dmem_addr[0] && ((dmem.dmem_wstrb == 4'h3) || (dmem.dmem_wstrb == 4'hC)));
    assign blocked       = blocked_q;
    assign dmem.dmem_err = (state_q == S_DONE) && blocked_q;

    always_ff @(posedge clk) begin
        if (rst) blocked_q <= 1'b0;
        else     blocked_q <= blocked_d;
    end

    always_comb begin
        blocked_d = blocked_q;
        if ((state_q == S_IDLE) && dmem.dmem_req) blocked_d = misaligned;
    end
`else
    assign blocked       = 1'b0;
    assign dmem.dmem_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (dmem.dmem_req) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(LAT - 1);
                    idx_d   = dmem.dmem_addr[AW+1:2];
                    we_d    = dmem.dmem_we;
                    wdata_d = dmem.dmem_wdata;
                    wstrb_d = dmem.dmem_wstrb;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
                else               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // A reset landing on the commit edge must cancel the pending store.
    assign wr_en  = commit && we_q && !blocked && !rst;
    assign rd_en  = commit && !we_q && !blocked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Fetch reads the pre-write contents when it collides with a store commit.
    always_ff @(posedge clk) begin
        if (rst) imem_rdata_q <= NOP;
        else     imem_rdata_q <= mem[fetch_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[idx_q];
    end

    assign imem_rdata       = imem_rdata_q;
    assign dmem.dmem_rdata  = rdata_q;
    assign dmem.dmem_ready  = (state_q == S_DONE);
    assign dmem.dmem_busy   = ((state_q == S_IDLE) && dmem.dmem_req) || (state_q == S_BUSY);
endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized bench for core_mem_responder against a transaction-timing memory model.
module tb_core_mem_responder;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [31:0] imem_rdata;
    bit          rand_fetch = 1'b0;

    core_mem_responder_if bus();

    core_mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: memory image with per-byte validity, and the
    // accepted transaction tracked by the cycle it was accepted in.
    logic [31:0] m_mem   [DEPTH];
    logic [3:0]  m_known [DEPTH];
    bit          m_valid = 1'b0;
    bit          in_txn  = 1'b0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic        t_we;
    int          t_idx;
    logic [31:0] t_wdata;
    logic [3:0]  t_wstrb;
    bit          t_mis;
    logic [31:0] m_rdata;
    bit          m_rdata_known = 1'b0;
    logic [31:0] m_fetch;
    bit          m_fetch_known = 1'b0;

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit mis_of(input logic [31:0] a, input logic [3:0] s);
`ifdef DMEM_ALIGN_CHECK_EN
        return ((a % 4) != 0 && s == 4'hF) || ((a % 2) == 1 && (s == 4'h3 || s == 4'hC));
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int          k;
        bit          e_busy, e_ready, e_err;
        logic        s_rst, s_req, s_we;
        logic [31:0] s_addr, s_wdata, s_iaddr;
        logic [3:0]  s_wstrb;
        int          fi;
        for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 4'h0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                k       = cyc - acc_cyc;
                e_busy  = in_txn ? (k >= 1 && k <= int'(LAT)) : bus.dmem_req;
                e_ready = in_txn && (k == int'(LAT) + 1);
                e_err   = e_ready && t_mis;
                check("busy",  32'(bus.dmem_busy),  32'(e_busy));
                check("ready", 32'(bus.dmem_ready), 32'(e_ready));
                check("err",   32'(bus.dmem_err),   32'(e_err));
                if (m_rdata_known) check("dmem_rdata", bus.dmem_rdata, m_rdata);
                if (m_fetch_known) check("imem_rdata", imem_rdata, m_fetch);
            end
            s_rst   = rst;
            s_req   = bus.dmem_req;
            s_we    = bus.dmem_we;
            s_addr  = bus.dmem_addr;
            s_wdata = bus.dmem_wdata;
            s_wstrb = bus.dmem_wstrb;
            s_iaddr = imem_addr;
            @(posedge clk);
            if (s_rst) begin
                m_valid       = 1'b1;
                in_txn        = 1'b0;
                m_rdata       = '0;
                m_rdata_known = 1'b1;
                m_fetch       = NOP;
                m_fetch_known = 1'b1;
            end else if (m_valid) begin
                fi            = word_of(s_iaddr);
                m_fetch       = m_mem[fi];
                m_fetch_known = (m_known[fi] == 4'hF);
                if (in_txn) begin
                    k = cyc - acc_cyc;
                    if (k == int'(LAT) && !t_mis) begin
                        if (t_we) begin
                            for (int b = 0; b < 4; b++) begin
                                if (t_wstrb[b]) begin
                                    m_mem[t_idx][8*b +: 8] = t_wdata[8*b +: 8];
                                    m_known[t_idx][b]      = 1'b1;
                                end
                            end
                        end else begin
                            m_rdata       = m_mem[t_idx];
                            m_rdata_known = (m_known[t_idx] == 4'hF);
                        end
                    end else if (k == int'(LAT) + 1) begin
                        in_txn = 1'b0;
                    end
                end else if (s_req) begin
                    in_txn  = 1'b1;
                    acc_cyc = cyc;
                    t_we    = s_we;
                    t_idx   = word_of(s_addr);
                    t_wdata = s_wdata;
                    t_wstrb = s_wstrb;
                    t_mis   = mis_of(s_addr, s_wstrb);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_fetch) imem_addr = $urandom_range(0, DEPTH * 8 - 1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit hold,
                       output bit got, output int nbusy, output logic err);
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = we;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
        bus.dmem_wstrb = wstrb;
        got   = 1'b0;
        nbusy = 0;
        err   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.dmem_busy) nbusy++;
            tick();
            if (bus.dmem_ready) begin
                got = 1'b1;
                err = bus.dmem_err;
                if (!hold) bus.dmem_req = 1'b0;
            end
        end
        if (!got) begin
            bus.dmem_req = 1'b0;
            checks++;
            errors++;
            $display("FAIL txn_timeout: no ready within 40 cycles for addr %08h", addr);
        end
    endtask

    initial begin
        bit          got, saw_ready;
        int          nb;
        logic        err;
        logic [31:0] exp_mis;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.dmem_wstrb = '0;

        tick();
        tick();
        check("reset_imem",  imem_rdata,               NOP);
        check("reset_ready", 32'(bus.dmem_ready),      32'd0);
        check("reset_rdata", bus.dmem_rdata,           32'd0);
        rst = 1'b0;

        txn(1'b1, 32'h0, 32'hCAFE_0001, 4'hF, 1'b0, got, nb, err);
        tick();
        check("fetch_word0", imem_rdata, 32'hCAFE_0001);

        rst = 1'b1;
        tick();
        tick();
        check("reset2_imem", imem_rdata, NOP);
        rst = 1'b0;
        tick();
        check("fetch_after_reset", imem_rdata, 32'hCAFE_0001);

        txn(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, got, nb, err);
        check("store_ready_seen", 32'(got), 32'd1);
        check("store_busy_cycles", 32'(nb), 32'd3);
        tick();
        txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, got, nb, err);
        check("load_deadbeef", bus.dmem_rdata, 32'hDEAD_BEEF);

        tick();
        txn(1'b1, 32'h40, 32'h1122_3344, 4'b0101, 1'b0, got, nb, err);
        tick();
        txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, got, nb, err);
        check("load_strobed", bus.dmem_rdata, 32'hDE22_BE44);
        tick();
        txn(1'b0, 32'h40 + DEPTH * 4, 32'h0, 4'hF, 1'b0, got, nb, err);
        check("load_alias", bus.dmem_rdata, 32'hDE22_BE44);

        tick();
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = 1'b1;
        bus.dmem_addr  = 32'h40;
        bus.dmem_wdata = 32'h0;
        bus.dmem_wstrb = 4'hF;
        tick();
        tick();
        rst          = 1'b1;
        bus.dmem_req = 1'b0;
        tick();
        rst       = 1'b0;
        saw_ready = bus.dmem_ready;
        repeat (4) begin
            tick();
            saw_ready = saw_ready | bus.dmem_ready;
        end
        check("reset_mid_store_no_ready", 32'(saw_ready), 32'd0);
        txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, got, nb, err);
        check("reset_mid_store_kept", bus.dmem_rdata, 32'hDE22_BE44);

        tick();
        txn(1'b1, 32'h80, 32'h1234_5678, 4'hF, 1'b0, got, nb, err);
        imem_addr = 32'h80;
        tick();
        tick();
        txn(1'b1, 32'h80, 32'h5555_AAAA, 4'hF, 1'b0, got, nb, err);
        check("collision_old", imem_rdata, 32'h1234_5678);
        tick();
        check("collision_new", imem_rdata, 32'h5555_AAAA);

        tick();
        txn(1'b1, 32'h42, 32'h9999_9999, 4'hF, 1'b0, got, nb, err);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign_err", 32'(err), 32'd1);
        exp_mis = 32'hDE22_BE44;
`else
        check("misalign_err", 32'(err), 32'd0);
        exp_mis = 32'h9999_9999;
`endif
        tick();
        txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, got, nb, err);
        check("misalign_mem", bus.dmem_rdata, exp_mis);

        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            txn(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, got, nb, err);
        end

        rand_fetch = 1'b1;
        for (int n = 0; n < 300; n++) begin
            bit          hold;
            logic [31:0] ra;
            repeat ($urandom_range(0, 3)) tick();
            ra   = $urandom_range(0, DEPTH * 16 - 1);
            hold = ($urandom_range(0, 7) == 0);
            txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                hold, got, nb, err);
            if (!hold) tick();
        end
        bus.dmem_req = 1'b0;
        rand_fetch   = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Memory-side responder for the five-stage RISC_V pipeline. It serves the core's instruction fetch port with a registered read, and its data load/store port through a wait-state FSM with a req/ready handshake. It produces a busy signal that the core ORs into its stall logic. It sits outside the core at top level, with one word-addressed storage array shared by both ports.

## Interface
- `DEPTH`, 1024: storage size in 32-bit words; power of two, 16..65536.
- `LAT`, 2: data-access wait cycles spent in BUSY; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_addr` in 32: fetch byte address, driven from the core's `pc_out`.
- `imem_rdata` out 32: fetched instruction, to the core's `ir`.
- `dmem_req` in 1: data request; held high by the core until `dmem_ready`.
- `dmem_we` in 1: 1 = store, 0 = load.
- `dmem_addr` in 32: data byte address (the core's `alu_MEM`).
- `dmem_wdata` in 32: store data (the core's `writedata_MEM`).
- `dmem_wstrb` in 4: byte-lane write enables; bit i enables byte i.
- `dmem_rdata` out 32: load data, to the core's `readdata_MEM`.
- `dmem_ready` out 1: one-cycle completion pulse.
- `dmem_busy` out 1: stall request to the core.
- `dmem_err` out 1: misalignment error pulse; tied 0 unless `DMEM_ALIGN_CHECK_EN` is defined.

## Operation
- **Word index.** `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- **Fetch port.** `imem_rdata <= mem[index(imem_addr)]` every cycle. There is no stall input; the fetch port always reads.
- **Data FSM states:** IDLE, BUSY, DONE.
- **IDLE.** If `dmem_req`=1:
  - latch addr, we, wdata and wstrb;
  - load `cnt` <= LAT-1;
  - go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY.**
  - If `cnt`!=0: `cnt` <= `cnt`-1 and stay.
  - If `cnt`==0: commit the access and go to DONE.
    - Store: write only the bytes whose strobe bit is 1.
    - Load: `dmem_rdata` <= full word.
- **DONE.** `dmem_ready`=1 for this cycle only; next state is IDLE.
- **Back-to-back requests.** A request still high in DONE is a new request only if it is still high in the following IDLE cycle. The core must drop `dmem_req` in the cycle it sees `dmem_ready`.
- **Inputs during BUSY/DONE.** Ignored; the latched copies are used.
- **`dmem_busy`** = (state==IDLE && `dmem_req`) || state==BUSY. It is combinational and low in DONE, so the core advances in the ready cycle.
- **`dmem_rdata`** holds its value until the next load commits; stores do not change it.
- **Store with `wstrb`=0.** Completes normally with no memory change.
- **Simultaneous fetch and store to the same word in the same edge.** `imem_rdata` returns the old word (read-before-write). The new value is visible on the next fetch.
- **Reset during BUSY.** Returns to IDLE and the pending store is not performed. Memory contents are never cleared by reset.

## Timing
- **Fetch latency.** 1 cycle: the address presented in cycle t gives data in cycle t+1.
- **Data latency.** Request first seen in IDLE at cycle t: BUSY during cycles t+1..t+LAT, and `dmem_ready` high in cycle t+LAT+1. Total is LAT+1 cycles of stall.
- **Throughput.** One data access per LAT+2 cycles.
- **Reset values:**
  - state = IDLE, `cnt` = 0;
  - `imem_rdata` = 32'h0000_0013 (NOP);
  - `dmem_rdata` = 0;
  - `dmem_ready` = 0;
  - `dmem_err` = 0.
- **`dmem_busy` during reset.** Follows `dmem_req` combinationally, because state is IDLE.

## Configuration
- **Macro:** `DMEM_ALIGN_CHECK_EN`.
- **Defined:** at acceptance in IDLE, the access is flagged misaligned if either:
  - `dmem_addr[1:0]`!=0 with `dmem_wstrb`==4'hF, or
  - `dmem_addr[0]`=1 with a halfword strobe (4'h3 or 4'hC).
  
  A flagged access still runs the full FSM timing, but:
  - no write is performed;
  - `dmem_rdata` is unchanged;
  - `dmem_err` pulses high together with `dmem_ready`.
- **Undefined:** `addr[1:0]` is ignored, there is no alignment checking logic, and `dmem_err` is constant 0.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `dmem_req`=0 -> `imem_rdata`=0x00000013, `dmem_ready`=0, `dmem_rdata`=0; after release, fetching address 0x0 yields mem[0] one cycle later.
- **Store then load.** LAT=2. Store 0xDEADBEEF to 0x40 with `wstrb`=4'hF -> `dmem_busy` high for 3 cycles, `dmem_ready` in cycle 3. A following load from 0x40 -> `dmem_rdata`=0xDEADBEEF.
- **Byte strobes and aliasing.** Word 0x40 holds 0xDEADBEEF. Store 0x11223344 to 0x40 with `wstrb`=4'b0101 -> a load returns 0xDE22BE44. A load from 0x40+DEPTH*4 returns the same value.
- **Reset mid-store.** Assert `rst` in the second BUSY cycle of a store of 0x0 to 0x40 -> FSM returns to IDLE, no `dmem_ready`, and a later load from 0x40 returns the prior value.
- **Fetch/store collision.** A store to 0x80 commits while `imem_addr`=0x80 -> that cycle's fetch shows the old word and the next cycle shows the new word.
- **Misalignment.** With `DMEM_ALIGN_CHECK_EN` defined: a word store to 0x42 -> `dmem_err`=1 together with `dmem_ready`, and memory is unchanged. Without the macro: `dmem_err` stays 0 and word 0x40 is written.
